// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between the fetch stage, instruction memory, branch resolution and decode.
// The fetch unit connects through the master modport; the surrounding pipeline uses slave.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc, if_fault,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc, if_fault,
        output if_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32 instruction fetch: owns the fetch PC, issues credit-limited word requests,
// buffers in-order responses for decode and discards in-flight responses after a redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [29:0]           fetch_word;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         discard;
    logic [CW-1:0]         fifo_count;
    logic [AW-1:0]         pq_wr, pq_rd;
    logic [AW-1:0]         of_wr, of_rd;
    logic [31:0]           pq_pc   [FIFO_DEPTH];
    logic [31:0]           of_pc   [FIFO_DEPTH];
    logic [31:0]           of_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] of_err;

    logic          redirect;
    logic [CW:0]   in_use;
    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic          unused_bits;

    assign redirect    = bus.redirect_valid;
    assign unused_bits = ^bus.redirect_pc[1:0];

    // Buffered plus in-flight words may never exceed the buffer size, so every response has a slot.
    assign in_use             = {1'b0, fifo_count} + {1'b0, outstanding};
    assign bus.imem_req_valid = !rst && !redirect && (in_use < {1'b0, DEPTH_C});
    assign bus.imem_req_addr  = {fetch_word, 2'b00};

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire = !rst && bus.imem_rsp_valid;
    assign push     = rsp_fire && !redirect && (discard == '0);
    assign pop      = bus.if_valid && bus.if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_word  <= RESET_PC[31:2];
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
            of_wr       <= '0;
            of_rd       <= '0;
        end else begin
            if (req_fire) pq_wr <= pq_wr + AW'(1);
            if (rsp_fire) pq_rd <= pq_rd + AW'(1);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (redirect) begin
                // A response landing in the redirect cycle is already gone, so it is not owed a discard.
                fetch_word <= bus.redirect_pc[31:2];
                discard    <= outstanding - CW'(rsp_fire);
                fifo_count <= '0;
                of_wr      <= '0;
                of_rd      <= '0;
            end else begin
                if (req_fire) fetch_word <= fetch_word + 30'd1;
                if (rsp_fire && (discard != '0)) discard <= discard - CW'(1);
                if (push) of_wr <= of_wr + AW'(1);
                if (pop) of_rd <= of_rd + AW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) pq_pc[pq_wr] <= bus.imem_req_addr;
        if (push) begin
            of_pc[of_wr]   <= pq_pc[pq_rd];
            of_data[of_wr] <= bus.imem_rsp_data;
            of_err[of_wr]  <= bus.imem_rsp_err;
        end
    end

    // Head of the buffer drives decode directly; empty or reset shows all-zero outputs.
    assign bus.if_valid = !rst && (fifo_count != '0);
    assign bus.if_pc    = bus.if_valid ? of_pc[of_rd] : 32'h0;
    assign bus.if_fault = bus.if_valid && of_err[of_rd];
    assign bus.if_instr = !bus.if_valid ? 32'h0 : (of_err[of_rd] ? NOP : of_data[of_rd]);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_count == DEPTH_C)));
    a_counters: assert property (@(posedge clk) disable iff (rst)
        (discard <= outstanding) && (outstanding <= DEPTH_C));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] XOR_K  = 32'hA5A5_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] v; int c; } rlog_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; int c; } ilog_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();
    instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mreq_t       mq[$];
    rlog_t       req_log[$];
    ilog_t       if_log[$];
    int          cyc = 0;
    int          c0 = 0;
    int          lat = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Request and decode handshakes are sampled mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (rst) mq.delete();
        else if (bus.imem_req_valid && bus.imem_req_ready) begin
            mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
            req_log.push_back('{v: bus.imem_req_addr, c: cyc});
        end
        if (!rst && bus.if_valid && bus.if_ready)
            if_log.push_back('{pc: bus.if_pc, instr: bus.if_instr, fault: bus.if_fault, c: cyc});
    end

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_rsp_err   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_rsp_valid = 1'b0;
            if (mq.size() != 0 && mq[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mq[0].addr ^ XOR_K;
                bus.imem_rsp_err   = (mq[0].addr == err_addr);
                void'(mq.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_at(input logic [31:0] pc, input int l);
        tick(1);
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        tick(2);
        rst = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick(1);
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        lat = l;
        req_log.delete();
        if_log.delete();
        c0 = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b1;
        tick(3);
        @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
        checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h want 0", bus.if_instr); end
        checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h want 0", bus.if_pc); end
        checks++; if (bus.if_fault !== 1'b0) begin errors++; $display("FAIL reset_if_fault: got %b want 0", bus.if_fault); end
    endtask

    task automatic test_stream_wrap();
        logic [31:0] exp;
        tick(1);
        rst = 1'b0;
        lat = 1;
        req_log.delete();
        if_log.delete();
        c0 = cyc;
        tick(10);
        checks++; if (req_log.size() != 10) begin errors++; $display("FAIL stream_req_count: got %0d want 10", req_log.size()); end
        for (int i = 0; i < req_log.size() && i < 10; i++) begin
            exp = RST_PC + 32'(4 * i);
            checks++;
            if (req_log[i].v !== exp || req_log[i].c != c0 + i) begin
                errors++;
                $display("FAIL stream_req[%0d]: got addr %h cyc %0d want addr %h cyc %0d", i, req_log[i].v, req_log[i].c - c0, exp, i);
            end
        end
        checks++; if (if_log.size() != 8) begin errors++; $display("FAIL stream_if_count: got %0d want 8", if_log.size()); end
        for (int i = 0; i < if_log.size() && i < 8; i++) begin
            exp = RST_PC + 32'(4 * i);
            checks++;
            if (if_log[i].pc !== exp || if_log[i].instr !== (exp ^ XOR_K) || if_log[i].fault !== 1'b0 || if_log[i].c != c0 + 2 + i) begin
                errors++;
                $display("FAIL stream_if[%0d]: got pc %h instr %h fault %b cyc %0d want pc %h instr %h fault 0 cyc %0d",
                         i, if_log[i].pc, if_log[i].instr, if_log[i].fault, if_log[i].c - c0, exp, exp ^ XOR_K, 2 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.if_ready = 1'b0;
        start_at(32'h0, 1);
        tick(9);
        @(negedge clk);
        checks++; if (req_log.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d want 4", req_log.size()); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid); end
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== XOR_K) begin
            errors++;
            $display("FAIL bp_head: got valid %b pc %h instr %h want valid 1 pc 0 instr %h", bus.if_valid, bus.if_pc, bus.if_instr, XOR_K);
        end
        tick(1);
        bus.if_ready = 1'b1;
        tick(8);
        checks++; if (if_log.size() != 8) begin errors++; $display("FAIL bp_if_count: got %0d want 8", if_log.size()); end
        for (int i = 0; i < if_log.size() && i < 8; i++) begin
            checks++;
            if (if_log[i].pc !== 32'(4 * i) || if_log[i].instr !== (32'(4 * i) ^ XOR_K)) begin
                errors++;
                $display("FAIL bp_order[%0d]: got pc %h instr %h want pc %h", i, if_log[i].pc, if_log[i].instr, 32'(4 * i));
            end
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h600;
        tick(1);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL bp_flush_if_valid: got %b want 0", bus.if_valid); end
    endtask

    task automatic test_redirect_discard();
        bus.if_ready = 1'b1;
        start_at(32'h10, 3);
        tick(2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick(1);
        bus.redirect_valid = 1'b0;
        tick(7);
        checks++;
        if (req_log.size() < 3 || req_log[0].v !== 32'h10 || req_log[1].v !== 32'h14 || req_log[2].v !== 32'h200 || req_log[2].c != c0 + 3) begin
            errors++;
            $display("FAIL rd_reqs: got %0d reqs, third %h at cyc %0d want 10,14,200 at cyc 3",
                     req_log.size(), (req_log.size() > 2) ? req_log[2].v : 32'h0, (req_log.size() > 2) ? req_log[2].c - c0 : -1);
        end
        checks++;
        if (if_log.size() < 3 || if_log[0].pc !== 32'h200 || if_log[0].c != c0 + 7 || if_log[1].pc !== 32'h204 || if_log[2].pc !== 32'h208) begin
            errors++;
            $display("FAIL rd_if: got %0d entries, first pc %h cyc %0d want 200,204,208 from cyc 7",
                     if_log.size(), (if_log.size() > 0) ? if_log[0].pc : 32'h0, (if_log.size() > 0) ? if_log[0].c - c0 : -1);
        end
        for (int i = 0; i < if_log.size(); i++) begin
            checks++;
            if (if_log[i].pc === 32'h10 || if_log[i].pc === 32'h14) begin
                errors++;
                $display("FAIL rd_stale[%0d]: got pc %h want no stale pc", i, if_log[i].pc);
            end
        end
    endtask

    task automatic test_redirect_same_cycle();
        bus.if_ready = 1'b1;
        start_at(32'h80, 1);
        tick(1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        tick(1);
        bus.redirect_valid = 1'b0;
        tick(4);
        checks++;
        if (req_log.size() < 2 || req_log[1].v !== 32'h100 || req_log[1].c != c0 + 2) begin
            errors++;
            $display("FAIL sc_req: got %0d reqs, second %h want 100 at cyc 2", req_log.size(), (req_log.size() > 1) ? req_log[1].v : 32'h0);
        end
        checks++;
        if (if_log.size() < 1 || if_log[0].pc !== 32'h100 || if_log[0].instr !== (32'h100 ^ XOR_K) || if_log[0].c != c0 + 4) begin
            errors++;
            $display("FAIL sc_if: got %0d entries, first pc %h instr %h want pc 100 instr %h at cyc 4",
                     if_log.size(), (if_log.size() > 0) ? if_log[0].pc : 32'h0, (if_log.size() > 0) ? if_log[0].instr : 32'h0, 32'h100 ^ XOR_K);
        end
    endtask

    task automatic test_back_to_back();
        bus.if_ready = 1'b1;
        start_at(32'h300, 3);
        tick(2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        tick(1);
        bus.redirect_pc    = 32'h500;
        tick(1);
        bus.redirect_valid = 1'b0;
        tick(6);
        checks++;
        if (req_log.size() < 3 || req_log[2].v !== 32'h500 || req_log[2].c != c0 + 4) begin
            errors++;
            $display("FAIL b2b_req: got %0d reqs, third %h want 500 at cyc 4", req_log.size(), (req_log.size() > 2) ? req_log[2].v : 32'h0);
        end
        checks++;
        if (if_log.size() < 1 || if_log[0].pc !== 32'h500 || if_log[0].c != c0 + 8) begin
            errors++;
            $display("FAIL b2b_if: got %0d entries, first pc %h want 500 at cyc 8", if_log.size(), (if_log.size() > 0) ? if_log[0].pc : 32'h0);
        end
    endtask

    task automatic test_fault_and_reset();
        logic [31:0] exp;
        bus.if_ready = 1'b1;
        err_addr = 32'h40;
        start_at(32'h38, 1);
        tick(8);
        checks++; if (if_log.size() != 6) begin errors++; $display("FAIL flt_count: got %0d want 6", if_log.size()); end
        if (if_log.size() >= 4) begin
            checks++;
            if (if_log[2].fault !== 1'b1 || if_log[2].instr !== NOP || if_log[2].pc !== 32'h40) begin
                errors++;
                $display("FAIL flt_entry: got fault %b instr %h pc %h want 1 %h 40", if_log[2].fault, if_log[2].instr, if_log[2].pc, NOP);
            end
            checks++;
            if (if_log[3].fault !== 1'b0 || if_log[3].instr !== (32'h44 ^ XOR_K) || if_log[3].pc !== 32'h44) begin
                errors++;
                $display("FAIL flt_next: got fault %b instr %h pc %h want 0 %h 44", if_log[3].fault, if_log[3].instr, if_log[3].pc, 32'h44 ^ XOR_K);
            end
            checks++;
            if (if_log[1].fault !== 1'b0 || if_log[1].instr !== (32'h3C ^ XOR_K)) begin
                errors++;
                $display("FAIL flt_prev: got fault %b instr %h want 0 %h", if_log[1].fault, if_log[1].instr, 32'h3C ^ XOR_K);
            end
        end
        err_addr = 32'hFFFF_FFFF;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_req_valid: got %b want 0", bus.imem_req_valid); end
        tick(1);
        rst = 1'b0;
        req_log.delete();
        if_log.delete();
        c0 = cyc;
        @(negedge clk);
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_if_valid: got %b want 0", bus.if_valid); end
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL rst_mid_restart: got valid %b addr %h want 1 %h", bus.imem_req_valid, bus.imem_req_addr, RST_PC);
        end
        tick(5);
        checks++; if (if_log.size() < 3) begin errors++; $display("FAIL rst_wrap_count: got %0d want 3", if_log.size()); end
        for (int i = 0; i < if_log.size() && i < 3; i++) begin
            exp = RST_PC + 32'(4 * i);
            checks++;
            if (if_log[i].pc !== exp || if_log[i].instr !== (exp ^ XOR_K)) begin
                errors++;
                $display("FAIL rst_wrap[%0d]: got pc %h instr %h want pc %h instr %h", i, if_log[i].pc, if_log[i].instr, exp, exp ^ XOR_K);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream_wrap();
        test_backpressure();
        test_redirect_discard();
        test_redirect_same_cycle();
        test_back_to_back();
        test_fault_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
